gray_to_binary_converter: RTL and testbench
===========================================

Name: gray_to_binary_converter

Overview:
- Iterative 128-bit Gray-to-binary converter, the inverse of the team's binary-to-Gray block. Sits in the same datapath and shares its start/valid handshake.
- Conversion is a serial prefix XOR from the MSB downward: b(127) = g(127), and b(n) = g(n) ^ b(n+1) for n = 126 down to 0.
- Processes one 8-bit chunk per cycle, MSB chunk first, carrying one bit between chunks. A full conversion takes 16 rounds.

Parameters:
- DATA_W, 128, total word width; must be a multiple of CHUNK_W.
- CHUNK_W, 8, bits converted per round.
- ROUNDS, DATA_W/CHUNK_W = 16, rounds per conversion; derived, not overridable.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- converter_start  input  1  start request; sampled only in WAIT.
- data_in  input  DATA_W  Gray-coded word; must be valid in the start cycle only.
- data_out  output  DATA_W  binary result; valid only while data_out_valid=1, else 0.
- data_out_valid  output  1  one-cycle pulse marking the result.
- busy  output  1  high in START and CONVERT; low in WAIT.

Behaviour:
- Reset (async): state=START; round counter=0; data_reg=0; carry=0. Outputs during and after reset, before the first result: data_out=0, data_out_valid=0, busy=1 while in START.
- States:
  - START: lasts exactly one cycle after reset release, then goes to WAIT. converter_start is ignored here.
  - WAIT: busy=0. When converter_start=1, go to CONVERT, load data_reg, counter becomes 1.
  - CONVERT: runs rounds 1..15. After round 15, return to WAIT.
- Round r (0..15) handles bits [DATA_W-1-CHUNK_W*r : DATA_W-CHUNK_W*(r+1)].
  - Round 0 covers bits 127:120 and is computed combinationally from data_in in the start cycle, with carry_in = 0.
  - Rounds 1..15 read data_reg, with carry_in = the registered carry.
- Chunk rule: b[7] = g[7] ^ carry_in; b[i] = g[i] ^ b[i+1] for i = 6..0. carry_out = b[0] is registered as the next carry_in.
- data_reg update per round: only the current chunk is replaced with its binary value; all other bits are held. In the start cycle, the untouched bits are taken from data_in.
- Completion (round 15):
  - The counter is 15 in CONVERT for that cycle.
  - data_out_valid=1 for that cycle only.
  - data_out is driven combinationally as {data_reg[127:8], b_chunk15}.
  - Same edge: counter→0, data_reg→0, carry→0, state→WAIT.
- Latency: start accepted at cycle T, data_out_valid at cycle T+15. Throughput is one conversion per 16 cycles minimum.
- converter_start while in CONVERT (including the valid cycle) is ignored and not queued. A start in the cycle after valid is accepted; this is back-to-back operation.
- Reset mid-conversion: the conversion is aborted with no valid pulse, the block passes through START, and data_in must be re-presented afterwards.
- Counter width is clog2(ROUNDS) = 4 bits. Wrap from 15 to 0 is forced by the completion logic, not by natural overflow.

Decomposition:
- Shared package holds:
  - DATA_W, CHUNK_W, ROUNDS.
  - State encodings START=0, WAIT=1, CONVERT=2. These must not collide in meaning with the binary-to-Gray block's encodings.
- One sub-module: gray_to_binary_xor_chain8.
  - Inputs: gray[7:0], carry_in.
  - Outputs: bin[7:0], carry_out (= bin[0]).
  - Purely combinational.
- The top level holds the FSM, counter, data_reg, carry, and the chunk input/output multiplexers.

Test Plan:
- Release reset; assert converter_start in the first post-reset cycle with data_in=128'h1 → start ignored (START state), busy=1, no valid pulse. Re-assert in WAIT → valid 15 cycles later with data_out=128'h1.
- data_in=128'h8000_0000_0000_0000_0000_0000_0000_0000 → data_out=128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF. This proves the carry propagates through all 16 chunks.
- data_in=128'h3 → data_out=128'h2. data_in=128'hC000_0000_0000_0000_0000_0000_0000_0000 → data_out=128'h8000_0000_0000_0000_0000_0000_0000_0000.
- Round trip: binary 128'h5 → binary-to-Gray block → 128'h7 → this block → 128'h5. Also loop random words through both blocks, compare against a reference model, and require equality.
- Hold converter_start=1 continuously with data_in=128'h7 → valid pulses exactly every 16 cycles, each with data_out=128'h5. data_out=0 on every cycle without valid.
- Assert rst at round 8 → no valid pulse, busy=1 for one START cycle, then WAIT. A new conversion of 128'h3 completes correctly with data_out=128'h2.

Source files
------------

// File: rtl/gray_to_binary_converter_pkg.sv
// Shared widths and FSM encodings for the iterative Gray-to-binary converter.
// State names carry a G2B_ prefix so they never alias the binary-to-Gray block.
package gray_to_binary_converter_pkg;

    localparam int DATA_W  = 128;
    localparam int CHUNK_W = 8;
    localparam int ROUNDS  = DATA_W / CHUNK_W;
    localparam int CNT_W   = $clog2(ROUNDS);

    typedef enum logic [1:0] {
        G2B_START   = 2'd0,
        G2B_WAIT    = 2'd1,
        G2B_CONVERT = 2'd2
    } g2b_state_e;

endpackage

// File: rtl/gray_to_binary_xor_chain8.sv
// One 8-bit slice of the MSB-first prefix XOR.
// carry_in is the binary bit just above this slice.
module gray_to_binary_xor_chain8 (
    input  logic [7:0] gray,
    input  logic       carry_in,
    output logic [7:0] bin,
    output logic       carry_out
);

    logic acc;

    always_comb begin
        bin = '0;
        acc = carry_in;
        for (int i = 7; i >= 0; i--) begin
            acc    = acc ^ gray[i];
            bin[i] = acc;
        end
    end

    assign carry_out = bin[0];

endmodule

// File: rtl/gray_to_binary_converter.sv
// Iterative 128-bit Gray-to-binary converter, one 8-bit chunk per cycle.
// Chunk 0 is converted straight from data_in in the cycle start is accepted.
module gray_to_binary_converter
    import gray_to_binary_converter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              converter_start,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_valid,
    output logic              busy
);

    g2b_state_e state;
    g2b_state_e state_nxt;

    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   ridx;
    logic [DATA_W-1:0]  data_reg;
    logic [DATA_W-1:0]  src_word;
    logic [DATA_W-1:0]  upd_word;
    logic               carry;
    logic [CHUNK_W-1:0] chunk_g;
    logic [CHUNK_W-1:0] chunk_b;
    logic               chunk_cin;
    logic               chunk_cout;
    logic               accept;
    logic               last;

    assign accept = (state == G2B_WAIT) && converter_start;
    assign last   = (state == G2B_CONVERT) && (cnt == CNT_W'(ROUNDS - 1));

    // The start cycle works on data_in as round 0; later rounds on data_reg.
    assign src_word  = accept ? data_in : data_reg;
    assign ridx      = accept ? '0 : cnt;
    assign chunk_cin = accept ? 1'b0 : carry;

    always_comb begin
        chunk_g = '0;
        for (int r = 0; r < ROUNDS; r++) begin
            if (ridx == CNT_W'(r)) begin
                chunk_g = src_word[DATA_W-1-CHUNK_W*r -: CHUNK_W];
            end
        end
    end

    gray_to_binary_xor_chain8 u_chain (
        .gray      (chunk_g),
        .carry_in  (chunk_cin),
        .bin       (chunk_b),
        .carry_out (chunk_cout)
    );

    always_comb begin
        upd_word = src_word;
        for (int r = 0; r < ROUNDS; r++) begin
            if (ridx == CNT_W'(r)) begin
                upd_word[DATA_W-1-CHUNK_W*r -: CHUNK_W] = chunk_b;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= G2B_START;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            G2B_START:   state_nxt = G2B_WAIT;
            G2B_WAIT:    if (converter_start) state_nxt = G2B_CONVERT;
            G2B_CONVERT: if (last) state_nxt = G2B_WAIT;
            default:     state_nxt = G2B_START;
        endcase
    end

    always_comb begin
        busy           = (state != G2B_WAIT);
        data_out_valid = last;
        data_out       = last ? upd_word : '0;
    end

    // Completion clears everything so the idle datapath holds zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            data_reg <= '0;
            carry    <= 1'b0;
        end else if (accept) begin
            cnt      <= CNT_W'(1);
            data_reg <= upd_word;
            carry    <= chunk_cout;
        end else if (last) begin
            cnt      <= '0;
            data_reg <= '0;
            carry    <= 1'b0;
        end else if (state == G2B_CONVERT) begin
            cnt      <= cnt + CNT_W'(1);
            data_reg <= upd_word;
            carry    <= chunk_cout;
        end
    end

endmodule

// File: tb/tb_gray_to_binary_converter.sv
// Randomized and directed checks of the converter against a prefix-XOR model.
// All stimulus changes and output samples happen on the falling edge.
module tb_gray_to_binary_converter;

    import gray_to_binary_converter_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              converter_start;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_out_valid;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;

    gray_to_binary_converter dut (
        .clk            (clk),
        .rst            (rst),
        .converter_start(converter_start),
        .data_in        (data_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Binary bit n is the XOR of every Gray bit at or above n.
    function automatic logic [DATA_W-1:0] ref_g2b(input logic [DATA_W-1:0] g);
        logic [DATA_W-1:0] b = '0;
        for (int s = 0; s < DATA_W; s++) b ^= (g >> s);
        return b;
    endfunction

    function automatic logic [DATA_W-1:0] ref_b2g(input logic [DATA_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [DATA_W-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_conv(input logic [DATA_W-1:0] g,
                            input logic [DATA_W-1:0] exp,
                            input string name);
        int guard = 0;
        logic [DATA_W-1:0] exp_out;
        while (busy !== 1'b0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s idle_wait: busy=%b required 0", name, busy);
            return;
        end
        converter_start = 1'b1;
        data_in = g;
        @(negedge clk);
        converter_start = 1'b0;
        data_in = rand_word();
        for (int k = 1; k <= ROUNDS - 1; k++) begin
            if (k > 1) @(negedge clk);
            exp_out = (k == ROUNDS - 1) ? exp : '0;
            n_cmp++;
            if (data_out_valid !== (k == ROUNDS - 1)) begin
                n_bad++;
                $display("FAIL %s valid@%0d: got %b required %b",
                         name, k, data_out_valid, k == ROUNDS - 1);
            end
            n_cmp++;
            if (data_out !== exp_out) begin
                n_bad++;
                $display("FAIL %s data@%0d: got %h required %h",
                         name, k, data_out, exp_out);
            end
            n_cmp++;
            if (busy !== 1'b1) begin
                n_bad++;
                $display("FAIL %s busy@%0d: got %b required 1", name, k, busy);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (data_out_valid !== 1'b0 || busy !== 1'b0 || data_out !== '0) begin
            n_bad++;
            $display("FAIL %s after: valid=%b busy=%b data=%h required 0 0 0",
                     name, data_out_valid, busy, data_out);
        end
    endtask

    task automatic test_reset();
        int seen = 0;
        rst = 1'b1;
        converter_start = 1'b0;
        data_in = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (data_out !== '0 || data_out_valid !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_state: data=%h valid=%b busy=%b required 0 0 1",
                     data_out, data_out_valid, busy);
        end
        rst = 1'b0;
        converter_start = 1'b1;
        data_in = 128'h1;
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL start_state_busy: got %b required 1", busy);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || data_out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL start_ignored: busy=%b valid=%b required 0 0",
                     busy, data_out_valid);
        end
        converter_start = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (data_out_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL no_pulse_after_ignored: got %0d bad cycles required 0", seen);
        end
        run_conv(128'h1, 128'h1, "first_conv");
    endtask

    task automatic test_directed();
        run_conv(128'h8000_0000_0000_0000_0000_0000_0000_0000,
                 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, "msb_carry");
        run_conv(128'h3, 128'h2, "three");
        run_conv(128'hC000_0000_0000_0000_0000_0000_0000_0000,
                 128'h8000_0000_0000_0000_0000_0000_0000_0000, "top_two");
        run_conv(ref_b2g(128'h5), 128'h5, "round_trip_5");
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] b;
        for (int i = 0; i < 20; i++) begin
            b = rand_word();
            run_conv(ref_b2g(b), b, "rand_round_trip");
        end
        for (int i = 0; i < 5; i++) begin
            b = rand_word();
            run_conv(b, ref_g2b(b), "rand_gray");
        end
    endtask

    task automatic test_back_to_back();
        int guard = 0;
        logic exp_v;
        while (busy !== 1'b0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        converter_start = 1'b1;
        data_in = 128'h7;
        for (int c = 1; c <= 4 * ROUNDS - 1; c++) begin
            @(negedge clk);
            exp_v = ((c % ROUNDS) == ROUNDS - 1);
            n_cmp++;
            if (data_out_valid !== exp_v) begin
                n_bad++;
                $display("FAIL b2b_valid@%0d: got %b required %b", c, data_out_valid, exp_v);
            end
            n_cmp++;
            if (data_out !== (exp_v ? 128'h5 : 128'h0)) begin
                n_bad++;
                $display("FAIL b2b_data@%0d: got %h required %h",
                         c, data_out, exp_v ? 128'h5 : 128'h0);
            end
        end
        converter_start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        int seen = 0;
        while (busy !== 1'b0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        converter_start = 1'b1;
        data_in = 128'h7;
        @(negedge clk);
        converter_start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (data_out_valid !== 1'b0 || busy !== 1'b1 || data_out !== '0) begin
            n_bad++;
            $display("FAIL mid_reset: valid=%b busy=%b data=%h required 0 1 0",
                     data_out_valid, busy, data_out);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_reset_start: busy=%b required 1", busy);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_wait: busy=%b required 0", busy);
        end
        repeat (20) begin
            @(negedge clk);
            if (data_out_valid !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL mid_reset_no_pulse: got %0d pulses required 0", seen);
        end
        run_conv(128'h3, 128'h2, "after_mid_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        converter_start = 1'b0;
        data_in = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
